// File: rtl/gemm_pkg.sv
// Shared types and constants for the shared gemm arbiter slice.
package gemm_pkg;

  localparam int WORD_W = 32;
  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  // One bit is enough to name either of the two requesters.
  typedef logic req_id_t;

  // In-flight op marker travelling alongside the engine latency.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  // Extract lane idx (0 = least significant byte) from a packed word.
  function automatic logic [LANE_W-1:0] get_lane(input logic [WORD_W-1:0] word,
                                                 input int unsigned idx);
    return word[idx*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/gemm_share_arb_if.sv
// Requester, engine and response signals of the shared gemm arbiter.
// Handshake: an op transfers in the cycle where req_valid[i] and req_ready[i]
// are both high; a requester keeps valid and operands stable until then.
// rsp_valid is a one-cycle pulse with no backpressure.
interface gemm_share_arb_if #(
  parameter int WORD_W = gemm_pkg::WORD_W
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*WORD_W-1:0] req_a;
  logic [2*WORD_W-1:0] req_b;
  logic [2*WORD_W-1:0] req_c;
  logic [2*WORD_W-1:0] req_d;
  logic [WORD_W-1:0]   eng_a;
  logic [WORD_W-1:0]   eng_b;
  logic [WORD_W-1:0]   eng_c;
  logic [WORD_W-1:0]   eng_d;
  logic                eng_valid;
  logic [WORD_W-1:0]   eng_cout;
  logic [1:0]          rsp_valid;
  logic [WORD_W-1:0]   rsp_data;
  logic                busy;

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d, eng_cout,
    output req_ready, eng_a, eng_b, eng_c, eng_d, eng_valid,
           rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_c, req_d, eng_cout,
    input  req_ready, eng_a, eng_b, eng_c, eng_d, eng_valid,
           rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/gemm_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last winner.
module gemm_rr_arb
  import gemm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  req_id_t ptr_q;
  req_id_t ptr_d;

  // Pointer register; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b1;
    else        ptr_q <= ptr_d;
  end

  // Pointer moves only when somebody is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = 1'b0;
    else if (grant[1]) ptr_d = 1'b1;
  end

  // A lone eligible requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/gemm_share_arb.sv
// Shares one gemm engine between two requesters: arbitrates, registers the
// winning operands, tracks in-flight ops with a tag pipeline matched to the
// engine latency and steers each result back to its issuer.
module gemm_share_arb
  import gemm_pkg::*;
#(
  parameter int WORD_W  = gemm_pkg::WORD_W,
  parameter int ENG_LAT = 1,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  gemm_share_arb_if.slave  bus
);

  localparam int CNT_W = 4;

  logic [1:0]        eligible;
  logic [1:0]        grant;
  req_id_t           grant_id;
  logic [WORD_W-1:0] sel_a, sel_b, sel_c, sel_d;
  logic [CNT_W-1:0]  cnt [2];
  tag_t              tag_q [ENG_LAT];
  tag_t              tag_out;
  req_id_t           eng_id;
  logic              eng_valid_q;
  logic [WORD_W-1:0] eng_a_q, eng_b_q, eng_c_q, eng_d_q;
  logic [1:0]        rsp_valid_q;
  logic [WORD_W-1:0] rsp_data_q;
  logic              busy_c;

  // Eligibility uses the registered count, so a response landing at the cap
  // does not free a slot until the following cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eligible[i] = bus.req_valid[i] && (cnt[i] < CNT_W'(MAX_OUT));
    end
  end

  gemm_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant    (grant)
  );

  assign bus.req_ready = grant;
  assign grant_id      = grant[1];

  // Operand mux from the granted requester's slice.
  always_comb begin
    sel_a = grant_id ? bus.req_a[2*WORD_W-1:WORD_W] : bus.req_a[WORD_W-1:0];
    sel_b = grant_id ? bus.req_b[2*WORD_W-1:WORD_W] : bus.req_b[WORD_W-1:0];
    sel_c = grant_id ? bus.req_c[2*WORD_W-1:WORD_W] : bus.req_c[WORD_W-1:0];
    sel_d = grant_id ? bus.req_d[2*WORD_W-1:WORD_W] : bus.req_d[WORD_W-1:0];
  end

  // Operand register into the engine; holds its value when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_valid_q <= 1'b0;
      eng_id      <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      eng_c_q     <= '0;
      eng_d_q     <= '0;
    end else begin
      eng_valid_q <= |grant;
      if (|grant) begin
        eng_id  <= grant_id;
        eng_a_q <= sel_a;
        eng_b_q <= sel_b;
        eng_c_q <= sel_c;
        eng_d_q <= sel_d;
      end
    end
  end

  // Tag pipeline: the last stage is valid exactly when eng_cout carries that op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ENG_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{valid: eng_valid_q, id: eng_id};
      for (int k = 1; k < ENG_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_out = tag_q[ENG_LAT-1];

  // Capture the engine result and pulse the owner's response bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= {tag_out.valid && tag_out.id, tag_out.valid && !tag_out.id};
      if (tag_out.valid) rsp_data_q <= bus.eng_cout;
    end
  end

  // Outstanding counters: accept and response in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i] && !rsp_valid_q[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (!grant[i] && rsp_valid_q[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // Busy whenever any op is issued, in the engine or still owed a response.
  always_comb begin
    busy_c = eng_valid_q || (cnt[0] != '0) || (cnt[1] != '0);
    for (int k = 0; k < ENG_LAT; k++) busy_c = busy_c || tag_q[k].valid;
  end

  assign bus.eng_valid = eng_valid_q;
  assign bus.eng_a     = eng_a_q;
  assign bus.eng_b     = eng_b_q;
  assign bus.eng_c     = eng_c_q;
  assign bus.eng_d     = eng_d_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_c;

endmodule
